// File: rtl/matvec_sequencer.sv
// Sequencer for the matrix-vector multiply datapath: loads the matrix FIFO and the vector bank,
// then streams the matrix row-major into the MAC while reporting row and job completion.
module matvec_sequencer #(
    parameter int MAX_N = 8,
    parameter int NIB_W = 4,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NIB_W-1:0] N_in,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  logic             m_full,
    input  logic             m_empty,
    output logic             m_push,
    output logic             m_pop,
    output logic             fifo_flush,
    output logic             v_we,
    output logic [NIB_W-1:0] v_addr,
    output logic             mac_en,
    output logic             mac_clr,
    output logic [NIB_W-1:0] row_idx,
    output logic             row_done,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_M,
        LOAD_V,
        COMPUTE,
        DONE
    } state_t;

    localparam logic [NIB_W-1:0] MAX_N_W = NIB_W'(MAX_N);

    state_t           state, state_nxt;
    logic [NIB_W-1:0] n_lat, n_m1, col, row, mac_row_q, row_idx_q;
    logic [CNT_W-1:0] ld_cnt, nn_m1, n_m1_ld;
    logic             start_ok, start_bad, last_m, last_v, last_col;
    logic             mac_en_q, mac_clr_q, mac_last_q, row_done_q, done_q, err_q, flush_q;

    assign start_ok  = start && (N_in != '0) && (N_in <= MAX_N_W);
    assign start_bad = start && !start_ok;

    // N*N evaluated at the counter width so N=MAX_N does not truncate.
    assign nn_m1    = CNT_W'(n_lat) * CNT_W'(n_lat) - CNT_W'(1);
    assign n_m1_ld  = CNT_W'(n_lat) - CNT_W'(1);
    assign n_m1     = n_lat - NIB_W'(1);
    assign last_m   = (ld_cnt == nn_m1);
    assign last_v   = (ld_cnt == n_m1_ld);
    assign last_col = (col == n_m1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rx_ready  = 1'b0;
        m_push    = 1'b0;
        m_pop     = 1'b0;
        v_we      = 1'b0;
        v_addr    = '0;
        case (state)
            IDLE: begin
                if (start_ok) state_nxt = LOAD_M;
            end
            LOAD_M: begin
                rx_ready = !m_full;
                m_push   = rx_valid && !m_full;
                if (m_push && last_m) state_nxt = LOAD_V;
            end
            LOAD_V: begin
                rx_ready = 1'b1;
                v_we     = rx_valid;
                v_addr   = ld_cnt[NIB_W-1:0];
                if (v_we && last_v) state_nxt = COMPUTE;
            end
            COMPUTE: begin
                m_pop  = !m_empty;
                v_addr = col;
                if (m_pop && last_col && (row == n_m1)) state_nxt = DONE;
            end
            DONE: begin
                if (row_done_q) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_lat      <= '0;
            ld_cnt     <= '0;
            col        <= '0;
            row        <= '0;
            mac_en_q   <= 1'b0;
            mac_clr_q  <= 1'b0;
            mac_last_q <= 1'b0;
            mac_row_q  <= '0;
            row_done_q <= 1'b0;
            row_idx_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            flush_q <= (state == IDLE) && start_ok;
            err_q   <= (state == IDLE) && start_bad;
            done_q  <= (state == DONE) && row_done_q;

            if ((state == IDLE) && start_ok) begin
                n_lat  <= N_in;
                ld_cnt <= '0;
                col    <= '0;
                row    <= '0;
            end

            if (m_push) ld_cnt <= last_m ? '0 : ld_cnt + CNT_W'(1);
            if (v_we)   ld_cnt <= last_v ? '0 : ld_cnt + CNT_W'(1);

            if (m_pop) begin
                if (last_col) begin
                    col <= '0;
                    row <= row + NIB_W'(1);
                end else begin
                    col <= col + NIB_W'(1);
                end
                mac_row_q <= row;
            end

            // MAC controls trail the pop by one cycle to line up with the FIFO read data.
            mac_en_q   <= m_pop;
            mac_clr_q  <= m_pop && (col == '0);
            mac_last_q <= m_pop && last_col;

            row_done_q <= mac_en_q && mac_last_q;
            if (mac_en_q && mac_last_q) row_idx_q <= mac_row_q;
        end
    end

    assign fifo_flush = flush_q;
    assign mac_en     = mac_en_q;
    assign mac_clr    = mac_clr_q;
    assign row_done   = row_done_q;
    assign row_idx    = row_idx_q;
    assign done       = done_q;
    assign err        = err_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_matvec_sequencer.sv
// Directed self-checking bench for matvec_sequencer: load, compute, stalls, errors and reset abort.
module tb_matvec_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, rx_valid, m_full, m_empty;
    logic [3:0] N_in;
    logic       rx_ready, m_push, m_pop, fifo_flush, v_we, mac_en, mac_clr, row_done, busy, done, err;
    logic [3:0] v_addr, row_idx;
    logic [18:0] outs;

    matvec_sequencer #(.MAX_N(8), .NIB_W(4), .CNT_W(7)) dut (
        .clk(clk), .rst(rst), .start(start), .N_in(N_in),
        .rx_valid(rx_valid), .rx_ready(rx_ready),
        .m_full(m_full), .m_empty(m_empty), .m_push(m_push), .m_pop(m_pop),
        .fifo_flush(fifo_flush), .v_we(v_we), .v_addr(v_addr),
        .mac_en(mac_en), .mac_clr(mac_clr), .row_idx(row_idx), .row_done(row_done),
        .busy(busy), .done(done), .err(err)
    );

    assign outs = {rx_ready, m_push, m_pop, fifo_flush, v_we, v_addr, mac_en, mac_clr,
                   row_idx, row_done, busy, done, err};

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-job event counters, cleared by the monitor whenever start is seen.
    int cur_n = 1;
    int cyc = 0;
    int n_push, n_vwe, n_pop, n_mac, n_clr, n_rd, n_done, n_err, n_flush, viol, first_pop, last_pop;

    always @(negedge clk) begin
        cyc++;
        if (start) begin
            if (N_in >= 4'd1 && N_in <= 4'd8) cur_n = int'(N_in);
            n_push = 0; n_vwe = 0; n_pop = 0; n_mac = 0; n_clr = 0; n_rd = 0;
            n_done = 0; n_err = 0; n_flush = 0; viol = 0; first_pop = 0; last_pop = 0;
        end
        if (!rst) begin
            if (m_push) begin
                if (m_full) viol++;
                n_push++;
            end
            if (v_we) begin
                if (v_addr != 4'(n_vwe)) viol++;
                n_vwe++;
            end
            if (m_pop) begin
                if (m_empty || n_vwe != cur_n || n_push != cur_n * cur_n) viol++;
                if (v_addr != 4'(n_pop % cur_n)) viol++;
                if (n_pop == 0) first_pop = cyc;
                last_pop = cyc;
                n_pop++;
            end
            if (row_done) begin
                if (n_mac != (n_rd + 1) * cur_n || row_idx != 4'(n_rd)) viol++;
                n_rd++;
            end
            if (mac_clr && !mac_en) viol++;
            if (mac_en) begin
                if (mac_clr != (n_mac % cur_n == 0)) viol++;
                if (mac_clr) n_clr++;
                n_mac++;
            end
            if (done) begin
                if (busy || n_rd != cur_n) viol++;
                n_done++;
            end
            if (err) n_err++;
            if (fifo_flush) n_flush++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start(input logic [3:0] n);
        start = 1'b1;
        N_in  = n;
        step();
        start = 1'b0;
    endtask

    // Runs one job; optional m_full stall after full_at pushes, m_empty stall after
    // empty_at pops, or an early return after abort_at pops.
    task automatic run_job(input int n, input int full_at, input int empty_at, input int abort_at);
        bit stalled = 1'b0;
        pulse_start(4'(n));
        rx_valid = 1'b1;
        for (int i = 0; i < 400 && (n_push + n_vwe) < n * n + n; i++) begin
            if (full_at > 0 && !stalled && n_push == full_at) begin
                stalled = 1'b1;
                m_full  = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checks++;
                    if (rx_ready !== 1'b0 || m_push !== 1'b0) begin
                        errors++;
                        $display("FAIL full_stall: rx_ready=%b m_push=%b, required 0 0", rx_ready, m_push);
                    end
                    step();
                end
                m_full = 1'b0;
            end else begin
                step();
            end
        end
        rx_valid = 1'b0;
        stalled  = 1'b0;
        for (int i = 0; i < 400 && n_done == 0; i++) begin
            if (abort_at > 0 && n_pop >= abort_at) return;
            if (empty_at > 0 && !stalled && n_pop == empty_at) begin
                stalled = 1'b1;
                m_empty = 1'b1;
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    checks++;
                    if (m_pop !== 1'b0 || v_addr !== 4'd2 || row_done !== 1'b0 || (k == 1 && mac_en !== 1'b0)) begin
                        errors++;
                        $display("FAIL empty_stall: m_pop=%b v_addr=%0d row_done=%b mac_en=%b, required 0 2 0 %b",
                                 m_pop, v_addr, row_done, mac_en, (k == 0));
                    end
                    step();
                end
                m_empty = 1'b0;
            end else begin
                step();
            end
        end
        checks++;
        if (n_done == 0) begin
            errors++;
            $display("FAIL job_timeout: N=%0d done never seen, required 1 pulse", n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; N_in = '0; rx_valid = 1'b0; m_full = 1'b0; m_empty = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", outs);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        run_job(2, 0, 0, 0);
        checks++; if (n_push !== 4)  begin errors++; $display("FAIL basic_push: got %0d required 4", n_push); end
        checks++; if (n_vwe !== 2)   begin errors++; $display("FAIL basic_vwe: got %0d required 2", n_vwe); end
        checks++; if (n_pop !== 4)   begin errors++; $display("FAIL basic_pop: got %0d required 4", n_pop); end
        checks++; if (last_pop - first_pop !== 3) begin errors++; $display("FAIL basic_b2b: pop span %0d required 3", last_pop - first_pop); end
        checks++; if (n_clr !== 2)   begin errors++; $display("FAIL basic_clr: got %0d required 2", n_clr); end
        checks++; if (n_rd !== 2)    begin errors++; $display("FAIL basic_row_done: got %0d required 2", n_rd); end
        checks++; if (n_done !== 1)  begin errors++; $display("FAIL basic_done: got %0d required 1", n_done); end
        checks++; if (n_flush !== 1) begin errors++; $display("FAIL basic_flush: got %0d required 1", n_flush); end
        checks++; if (viol !== 0)    begin errors++; $display("FAIL basic_protocol: %0d violations required 0", viol); end
        step();
    endtask

    task automatic test_illegal();
        logic [3:0] bad_n [2];
        bad_n[0] = 4'd0;
        bad_n[1] = 4'd9;
        for (int j = 0; j < 2; j++) begin
            pulse_start(bad_n[j]);
            @(negedge clk);
            checks++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL illegal_err: N=%0d err=%b busy=%b required 1 0", bad_n[j], err, busy);
            end
            step();
            @(negedge clk);
            checks++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL illegal_pulse: N=%0d err=%b busy=%b required 0 0", bad_n[j], err, busy);
            end
            step();
            checks++;
            if (n_err !== 1 || n_flush !== 0 || n_push !== 0) begin
                errors++;
                $display("FAIL illegal_side: err=%0d flush=%0d push=%0d required 1 0 0", n_err, n_flush, n_push);
            end
        end
    endtask

    task automatic test_full_stall();
        run_job(3, 2, 0, 0);
        checks++; if (n_push !== 9) begin errors++; $display("FAIL full_push: got %0d required 9", n_push); end
        checks++; if (n_vwe !== 3)  begin errors++; $display("FAIL full_vwe: got %0d required 3", n_vwe); end
        checks++; if (n_rd !== 3 || n_done !== 1) begin errors++; $display("FAIL full_result: row_done=%0d done=%0d required 3 1", n_rd, n_done); end
        checks++; if (viol !== 0)   begin errors++; $display("FAIL full_protocol: %0d violations required 0", viol); end
        step();
    endtask

    task automatic test_empty_stall();
        run_job(3, 0, 2, 0);
        checks++; if (n_pop !== 9 || n_mac !== 9) begin errors++; $display("FAIL empty_counts: pop=%0d mac=%0d required 9 9", n_pop, n_mac); end
        checks++; if (n_rd !== 3 || n_done !== 1) begin errors++; $display("FAIL empty_result: row_done=%0d done=%0d required 3 1", n_rd, n_done); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL empty_protocol: %0d violations required 0", viol); end
        step();
    endtask

    task automatic test_reset_mid();
        run_job(4, 0, 0, 5);
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h required 0", outs);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (busy !== 1'b0 || n_done !== 0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b done=%0d required 0 0", busy, n_done);
        end
        run_job(1, 0, 0, 0);
        checks++; if (n_push !== 1 || n_vwe !== 1 || n_pop !== 1) begin errors++; $display("FAIL n1_counts: push=%0d vwe=%0d pop=%0d required 1 1 1", n_push, n_vwe, n_pop); end
        checks++; if (n_mac !== 1 || n_clr !== 1) begin errors++; $display("FAIL n1_mac: mac=%0d clr=%0d required 1 1", n_mac, n_clr); end
        checks++; if (n_rd !== 1 || n_done !== 1) begin errors++; $display("FAIL n1_result: row_done=%0d done=%0d required 1 1", n_rd, n_done); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL n1_protocol: %0d violations required 0", viol); end
        step();
    endtask

    task automatic test_n8();
        run_job(8, 0, 0, 0);
        checks++; if (n_push !== 64) begin errors++; $display("FAIL n8_push: got %0d required 64", n_push); end
        checks++; if (n_vwe !== 8)   begin errors++; $display("FAIL n8_vwe: got %0d required 8", n_vwe); end
        checks++; if (n_pop !== 64)  begin errors++; $display("FAIL n8_pop: got %0d required 64", n_pop); end
        checks++; if (n_rd !== 8 || n_done !== 1) begin errors++; $display("FAIL n8_result: row_done=%0d done=%0d required 8 1", n_rd, n_done); end
        checks++; if (viol !== 0)    begin errors++; $display("FAIL n8_protocol: %0d violations required 0", viol); end
        step();
    endtask

    task automatic test_back_to_back();
        run_job(2, 0, 0, 0);
        run_job(3, 0, 0, 0);
        checks++; if (n_push !== 9 || n_pop !== 9) begin errors++; $display("FAIL b2b_counts: push=%0d pop=%0d required 9 9", n_push, n_pop); end
        checks++; if (n_rd !== 3 || n_done !== 1 || viol !== 0) begin errors++; $display("FAIL b2b_result: row_done=%0d done=%0d viol=%0d required 3 1 0", n_rd, n_done, viol); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_full_stall();
        test_empty_stall();
        test_reset_mid();
        test_n8();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
